// File: rtl/canny_pkg.sv
// Shared constants and frame-sequencer encoding for the Canny AXI-stream front ends.
package canny_pkg;

  localparam int LINE_W_DEF  = 1024;
  localparam int FRAME_H_DEF = 768;
  localparam int PKT_LEN_DEF = 128;
  localparam int COORD_W     = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } canny_state_t;

  function automatic logic [COORD_W-1:0] coord_inc(input logic [COORD_W-1:0] v,
                                                   input int unsigned limit);
    return (v == COORD_W'(limit - 1)) ? '0 : v + COORD_W'(1);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational read port; push ignored when full, pop when empty.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && !o_empty;
  assign o_rd_data = r_mem[r_rd_ptr];

  // Storage array needs no reset; occupancy alone defines valid entries.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/canny_axis_rx.sv
// AXI-stream receive front end: buffers gray pixels, tags them with col/row,
// and sequences one frame at a time with a tlast alignment monitor.
module canny_axis_rx
  import canny_pkg::*;
#(
  parameter int LINE_W     = LINE_W_DEF,
  parameter int FRAME_H    = FRAME_H_DEF,
  parameter int PKT_LEN    = PKT_LEN_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         s_axis_tdata,
  input  logic               s_axis_tvalid,
  input  logic               s_axis_tlast,
  output logic               s_axis_tready,
  input  logic               stall,
  input  logic               clr_err,
  output logic [7:0]         pix_out,
  output logic               pix_en,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               sol,
  output logic               frame_done,
  output logic               err_last
);

  localparam int TOTAL = LINE_W * FRAME_H;
  localparam int CNT_W = $clog2(TOTAL + 1);
  localparam int PKT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  canny_state_t       r_state;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic [CNT_W-1:0]   r_out_cnt;
  logic [PKT_W-1:0]   r_pkt_cnt;
  logic [COORD_W-1:0] r_ncol;
  logic [COORD_W-1:0] r_nrow;
  logic [7:0]         r_pix_out;
  logic               r_pix_en;
  logic [COORD_W-1:0] r_col;
  logic [COORD_W-1:0] r_row;
  logic               r_sol;
  logic               r_frame_done;
  logic               r_err_last;

  logic       w_full;
  logic       w_empty;
  logic [7:0] w_fifo_data;
  logic       w_accept;
  logic       w_pop;
  logic       w_last_beat;
  logic       w_tlast_exp;

  assign s_axis_tready = (r_state == ST_STREAM) && !w_full;
  assign w_accept      = s_axis_tvalid && s_axis_tready;
  assign w_pop         = !w_empty && !stall && (r_out_cnt != CNT_W'(TOTAL));
  assign w_last_beat   = w_accept && (r_beat_cnt == CNT_W'(TOTAL - 1));
  assign w_tlast_exp   = (r_pkt_cnt == PKT_W'(PKT_LEN - 1));

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_accept),
    .i_wr_data (s_axis_tdata),
    .i_pop     (w_pop),
    .o_rd_data (w_fifo_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  // Frame sequencer; beat and packet counters only move while streaming.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_beat_cnt   <= '0;
      r_pkt_cnt    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        ST_IDLE: r_state <= ST_STREAM;
        ST_STREAM: begin
          if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            r_pkt_cnt  <= w_tlast_exp ? '0 : r_pkt_cnt + PKT_W'(1);
          end
          if (w_last_beat) r_state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (w_empty && (r_out_cnt == CNT_W'(TOTAL))) begin
            r_state      <= ST_DONE;
            r_frame_done <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state    <= ST_STREAM;
          r_beat_cnt <= '0;
          r_pkt_cnt  <= '0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky misalignment flag: a fresh error outranks a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_last <= 1'b0;
    end else if (w_accept && (s_axis_tlast != w_tlast_exp)) begin
      r_err_last <= 1'b1;
    end else if (clr_err) begin
      r_err_last <= 1'b0;
    end else begin
      r_err_last <= r_err_last;
    end
  end

  // r_ncol/r_nrow hold the position of the next pixel to be issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_out <= 8'd0;
      r_pix_en  <= 1'b0;
      r_col     <= '0;
      r_row     <= '0;
      r_sol     <= 1'b0;
      r_out_cnt <= '0;
      r_ncol    <= '0;
      r_nrow    <= '0;
    end else begin
      r_pix_en <= w_pop;
      r_sol    <= w_pop && (r_ncol == '0);
      if (w_pop) begin
        r_pix_out <= w_fifo_data;
        r_col     <= r_ncol;
        r_row     <= r_nrow;
        r_out_cnt <= r_out_cnt + CNT_W'(1);
        r_ncol    <= coord_inc(r_ncol, LINE_W);
        if (r_ncol == COORD_W'(LINE_W - 1)) r_nrow <= coord_inc(r_nrow, FRAME_H);
      end else if (r_state == ST_DONE) begin
        r_out_cnt <= '0;
        r_ncol    <= '0;
        r_nrow    <= '0;
      end
    end
  end

  assign pix_out    = r_pix_out;
  assign pix_en     = r_pix_en;
  assign col        = r_col;
  assign row        = r_row;
  assign sol        = r_sol;
  assign frame_done = r_frame_done;
  assign err_last   = r_err_last;

endmodule

// File: tb/tb_canny_axis_rx.sv
// Directed bench for canny_axis_rx on an 8x2 frame with 4-beat packets,
// scored against a queue model of accepted beats and their frame positions.
`timescale 1ns/1ps
module tb_canny_axis_rx;

  localparam int LW    = 8;
  localparam int FH    = 2;
  localparam int PL    = 4;
  localparam int FD    = 16;
  localparam int TOTAL = LW * FH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_axis_tdata = 8'd0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tlast = 1'b0;
  logic        s_axis_tready;
  logic        stall = 1'b0;
  logic        clr_err = 1'b0;
  logic [7:0]  pix_out;
  logic        pix_en;
  logic [10:0] col;
  logic [10:0] row;
  logic        sol;
  logic        frame_done;
  logic        err_last;

  always #5 clk = ~clk;

  canny_axis_rx #(
    .LINE_W     (LW),
    .FRAME_H    (FH),
    .PKT_LEN    (PL),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .stall         (stall),
    .clr_err       (clr_err),
    .pix_out       (pix_out),
    .pix_en        (pix_en),
    .col           (col),
    .row           (row),
    .sol           (sol),
    .frame_done    (frame_done),
    .err_last      (err_last)
  );

  int         compared   = 0;
  int         mismatched = 0;
  int         test_id    = 0;
  int         out_idx    = 0;
  int         frames     = 0;
  int         pix_total  = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: every accepted beat leaves once, in order, at position index -> (idx%LW, idx/LW).
  always @(negedge clk) begin
    logic [7:0] e;
    if (rst) begin
      exp_q.delete();
      out_idx = 0;
    end else begin
      if (prev_stall) check("pix_en_in_stall", {31'd0, pix_en}, 32'd0);
      if (pix_en) begin
        pix_total++;
        check("pix_backlog", {31'd0, exp_q.size() != 0}, 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("pix_data", {24'd0, pix_out}, {24'd0, e});
          check("pix_col", {21'd0, col}, out_idx % LW);
          check("pix_row", {21'd0, row}, (out_idx / LW) % FH);
          check("pix_sol", {31'd0, sol}, {31'd0, (out_idx % LW) == 0});
        end
        if (test_id == 1 && out_idx == 8) begin
          check("t1_pix8_data", {24'd0, pix_out}, 32'h18);
          check("t1_pix8_col", {21'd0, col}, 32'd0);
          check("t1_pix8_row", {21'd0, row}, 32'd1);
          check("t1_pix8_sol", {31'd0, sol}, 32'd1);
        end
        if (test_id == 1 && out_idx == 15) begin
          check("t1_pix15_data", {24'd0, pix_out}, 32'h1F);
          check("t1_pix15_col", {21'd0, col}, 32'd7);
        end
        if (test_id == 5 && out_idx == 0) begin
          check("t5_first_data", {24'd0, pix_out}, 32'hA0);
          check("t5_first_pos", {10'd0, row, col}, 32'd0);
        end
        out_idx++;
      end else begin
        check("sol_without_pix", {31'd0, sol}, 32'd0);
      end
      if (frame_done) begin
        frames++;
        check("frame_len", out_idx, TOTAL);
        check("frame_q_empty", exp_q.size(), 32'd0);
        out_idx = 0;
      end
      if (s_axis_tvalid && s_axis_tready) exp_q.push_back(s_axis_tdata);
    end
    prev_stall = stall;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [7:0] d, input logic last, input logic clr);
    logic acc;
    int   n;
    s_axis_tdata = d; s_axis_tlast = last; s_axis_tvalid = 1'b1; clr_err = clr;
    acc = 1'b0; n = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = s_axis_tready;
      tick();
      n++;
    end
    check("send_accepted", {31'd0, acc}, 32'd1);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; clr_err = 1'b0;
  endtask

  task automatic drive_frame(input logic [7:0] base, input bit rv, input bit rs);
    int   k = 0;
    int   n = 0;
    logic acc;
    while (k < TOTAL && n < 3000) begin
      s_axis_tvalid = rv ? ($urandom_range(0, 2) != 0) : 1'b1;
      s_axis_tdata  = base + 8'(k);
      s_axis_tlast  = (k % PL) == (PL - 1);
      stall         = rs ? ($urandom_range(0, 3) == 0) : 1'b0;
      @(negedge clk);
      acc = s_axis_tvalid && s_axis_tready;
      tick();
      if (acc) k++;
      n++;
    end
    check("drive_complete", k, TOTAL);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; stall = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frames < target && n < 500) begin
      tick();
      n++;
    end
    check("frame_count", frames, target);
  endtask

  task automatic check_err(input string name, input logic exp);
    @(negedge clk);
    check(name, {31'd0, err_last}, {31'd0, exp});
    tick();
  endtask

  initial begin
    int k;
    int snap;
    tick(); tick();
    @(negedge clk);
    check("rst_tready", {31'd0, s_axis_tready}, 32'd0);
    check("rst_pix_en", {31'd0, pix_en}, 32'd0);
    check("rst_pix_out", {24'd0, pix_out}, 32'd0);
    check("rst_col_row", {10'd0, row, col}, 32'd0);
    check("rst_flags", {29'd0, sol, frame_done, err_last}, 32'd0);
    tick();
    rst = 1'b0;

    // continuous frame
    test_id = 1;
    drive_frame(8'h10, 1'b0, 1'b0);
    wait_frames(1);
    check("t1_err_last", {31'd0, err_last}, 32'd0);
    check("t1_pix_total", pix_total, 32'd16);

    // stall from frame start: buffer fills, then drains in order on release
    test_id = 2;
    stall = 1'b1; k = 0;
    for (int c = 0; c < 20; c++) begin
      logic acc;
      s_axis_tvalid = 1'b1; s_axis_tdata = 8'h40 + 8'(k); s_axis_tlast = (k % PL) == (PL - 1);
      @(negedge clk);
      acc = s_axis_tvalid && s_axis_tready;
      tick();
      if (acc) k++;
    end
    check("t2_buffered", k, 32'd16);
    @(negedge clk);
    check("t2_tready_low", {31'd0, s_axis_tready}, 32'd0);
    tick();
    s_axis_tvalid = 1'b0; stall = 1'b0;
    wait_frames(2);
    check("t2_pix_total", pix_total, 32'd32);

    // tlast alignment monitor
    test_id = 3;
    send_one(8'h60, 1'b0, 1'b0);
    check_err("t3_err_clean", 1'b0);
    send_one(8'h61, 1'b1, 1'b0);
    check_err("t3_err_set", 1'b1);
    send_one(8'h62, 1'b0, 1'b0);
    send_one(8'h63, 1'b1, 1'b0);
    check_err("t3_err_sticky", 1'b1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check_err("t3_err_clr", 1'b0);
    test_id = 4;
    send_one(8'h64, 1'b1, 1'b1);
    check_err("t4_set_wins", 1'b1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    check_err("t4_clr", 1'b0);
    for (int i = 5; i < TOTAL; i++) send_one(8'h60 + 8'(i), (i % PL) == (PL - 1), 1'b0);
    wait_frames(3);
    check("t4_err_after", {31'd0, err_last}, 32'd0);
    check("t4_pix_total", pix_total, 32'd48);

    // reset mid-frame with buffered beats
    test_id = 5;
    stall = 1'b1;
    for (int i = 0; i < 5; i++) send_one(8'h80 + 8'(i), i == 3, 1'b0);
    rst = 1'b1; tick(); rst = 1'b0; stall = 1'b0;
    snap = pix_total;
    repeat (10) tick();
    check("t5_no_stale_pix", pix_total, snap);
    drive_frame(8'hA0, 1'b0, 1'b0);
    wait_frames(4);
    check("t5_frame_pix", pix_total - snap, 32'd16);

    // two frames with random valid gaps and stalls
    test_id = 6;
    snap = pix_total;
    drive_frame(8'hC0, 1'b1, 1'b1);
    drive_frame(8'hE0, 1'b1, 1'b1);
    wait_frames(6);
    check("t6_pix_count", pix_total - snap, 32'd32);
    check("t6_err_last", {31'd0, err_last}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
